// File: rtl/nav_pkg.sv
// Shared codes for the navigation path: tone-detector direction codes,
// motor drive commands and the sequencer state encoding.
package nav_pkg;

    localparam logic [2:0] DIR_STRAIGHT = 3'b000;
    localparam logic [2:0] DIR_LEFT     = 3'b001;
    localparam logic [2:0] DIR_RIGHT    = 3'b010;
    localparam logic [2:0] DIR_BACK     = 3'b011;
    localparam logic [2:0] DIR_STOP     = 3'b100;
    localparam logic [2:0] DIR_FINISH   = 3'b111;

    localparam logic [2:0] MOT_HALT   = 3'b000;
    localparam logic [2:0] MOT_FWD    = 3'b001;
    localparam logic [2:0] MOT_TURN_L = 3'b010;
    localparam logic [2:0] MOT_TURN_R = 3'b011;
    localparam logic [2:0] MOT_SPIN   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_TURN  = 3'd2,
        ST_EXIT  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } navState_t;

    // The two unassigned codes 101 and 110 behave exactly like STOP.
    function automatic logic isStopCode(input logic [2:0] code);
        return (code == DIR_STOP) || (code == 3'b101) || (code == 3'b110);
    endfunction

    function automatic logic isMoveCode(input logic [2:0] code);
        return (code[2] == 1'b0);
    endfunction

    function automatic logic [2:0] turnCmdFor(input logic [2:0] dir);
        logic [2:0] cmd;
        cmd = MOT_FWD;
        case (dir)
            DIR_LEFT:  cmd = MOT_TURN_L;
            DIR_RIGHT: cmd = MOT_TURN_R;
            DIR_BACK:  cmd = MOT_SPIN;
            default:   cmd = MOT_FWD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous flag, plus a rising-edge pulse
// taken from the synchronized level.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic meta;
    logic syncQ;
    logic syncDly;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta    <= 1'b0;
            syncQ   <= 1'b0;
            syncDly <= 1'b0;
        end else begin
            meta    <= din;
            syncQ   <= meta;
            syncDly <= syncQ;
        end
    end

    assign level = syncQ;
    assign rise  = syncQ & ~syncDly;

endmodule

// File: rtl/nav_sequencer.sv
// Junction-driven navigation sequencer: latches a tone direction, waits for
// the next junction, performs the turn for a fixed time, then resumes forward.
module nav_sequencer
    import nav_pkg::*;
#(
    parameter int unsigned TURN_CYCLES     = 50_000_000,
    parameter int unsigned SPIN_CYCLES     = 100_000_000,
    parameter int unsigned STRAIGHT_CYCLES = 25_000_000,
    parameter int unsigned TIMEOUT_CYCLES  = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] tdDir,
    input  logic       junction,
    output logic [2:0] motorCmd,
    output logic       cmdAck,
    output logic       busy,
    output logic       finished,
    output logic       timeoutErr
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    navState_t   state;
    navState_t   nextState;
    logic [2:0]  dirReg;
    logic [2:0]  dirNext;
    logic [31:0] count;
    logic [31:0] turnLast;
    logic        ackNext;
    logic [2:0]  motorNext;
    logic        junctionLevel;
    logic        junctionRise;

    sync_edge junctionSync (
        .clk   (clk),
        .rst   (rst),
        .din   (junction),
        .level (junctionLevel),
        .rise  (junctionRise)
    );

    always_comb begin
        turnLast = 32'(STRAIGHT_CYCLES) - 32'd1;
        case (dirReg)
            DIR_LEFT, DIR_RIGHT: turnLast = 32'(TURN_CYCLES) - 32'd1;
            DIR_BACK:            turnLast = 32'(SPIN_CYCLES) - 32'd1;
            default:             turnLast = 32'(STRAIGHT_CYCLES) - 32'd1;
        endcase
    end

    // Junction events outrank the timeout when both land in the same cycle.
    always_comb begin
        nextState = state;
        dirNext   = dirReg;
        ackNext   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (isMoveCode(tdDir)) begin
                    dirNext   = tdDir;
                    ackNext   = 1'b1;
                    nextState = ST_ARMED;
                end else if (tdDir == DIR_FINISH) begin
                    nextState = ST_DONE;
                end
            end
            ST_ARMED: begin
                if (junctionRise) begin
                    nextState = ST_TURN;
                end else if (count == TIMEOUT_LAST) begin
                    nextState = ST_ERROR;
                end
            end
            ST_TURN: begin
                if (count == turnLast) begin
                    nextState = ST_EXIT;
                end
            end
            ST_EXIT: begin
                if (!junctionLevel && isStopCode(tdDir)) begin
                    nextState = ST_IDLE;
                end
            end
            ST_DONE: begin
                nextState = ST_DONE;
            end
            ST_ERROR: begin
                if (isStopCode(tdDir)) begin
                    nextState = ST_IDLE;
                end
            end
            default: begin
                nextState = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        motorNext = MOT_FWD;
        case (nextState)
            ST_TURN:            motorNext = turnCmdFor(dirNext);
            ST_DONE, ST_ERROR:  motorNext = MOT_HALT;
            default:            motorNext = MOT_FWD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            dirReg <= DIR_STRAIGHT;
        end else begin
            state  <= nextState;
            dirReg <= dirNext;
        end
    end

    // Cleared on every state change and saturating, so it can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 32'd0;
        end else if (nextState != state) begin
            count <= 32'd0;
        end else if (count != '1) begin
            count <= count + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            motorCmd   <= MOT_HALT;
            cmdAck     <= 1'b0;
            busy       <= 1'b0;
            finished   <= 1'b0;
            timeoutErr <= 1'b0;
        end else begin
            motorCmd   <= motorNext;
            cmdAck     <= ackNext;
            busy       <= (nextState == ST_ARMED) || (nextState == ST_TURN) ||
                          (nextState == ST_EXIT);
            finished   <= (nextState == ST_DONE);
            timeoutErr <= (nextState == ST_ERROR);
        end
    end

endmodule

// File: tb/tb_nav_sequencer.sv
// Directed self-checking bench for nav_sequencer with shortened timing
// parameters; each scenario task checks its own expected values.
module tb_nav_sequencer;

    logic       clk;
    logic       rst;
    logic [2:0] tdDir;
    logic       junction;
    logic [2:0] motorCmd;
    logic       cmdAck;
    logic       busy;
    logic       finished;
    logic       timeoutErr;

    int vectors;
    int miscompares;

    nav_sequencer #(
        .TURN_CYCLES     (8),
        .SPIN_CYCLES     (16),
        .STRAIGHT_CYCLES (4),
        .TIMEOUT_CYCLES  (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tdDir      (tdDir),
        .junction   (junction),
        .motorCmd   (motorCmd),
        .cmdAck     (cmdAck),
        .busy       (busy),
        .finished   (finished),
        .timeoutErr (timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts consecutive samples showing cmd, starting at the current one.
    task automatic measureRun(input logic [2:0] cmd, output int len, output int busyLow);
        len = 0;
        busyLow = 0;
        for (int i = 0; i < 40; i++) begin
            if (motorCmd !== cmd) break;
            len++;
            if (busy !== 1'b1) busyLow++;
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        vectors++;
        if (motorCmd !== 3'b000 || cmdAck !== 1'b0 || busy !== 1'b0 ||
            finished !== 1'b0 || timeoutErr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: motorCmd=%b ack=%b busy=%b fin=%b terr=%b expected 000 0 0 0 0",
                     motorCmd, cmdAck, busy, finished, timeoutErr);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (motorCmd !== 3'b001 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_release_fwd: motorCmd=%b busy=%b expected 001 0", motorCmd, busy);
        end
    endtask

    task automatic test_left();
        int len, busyLow;
        tdDir = 3'b001;
        tick();
        vectors++;
        if (cmdAck !== 1'b1 || busy !== 1'b1 || motorCmd !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL left_ack: ack=%b busy=%b motorCmd=%b expected 1 1 001", cmdAck, busy, motorCmd);
        end
        tdDir = 3'b100;
        tick();
        vectors++;
        if (cmdAck !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL left_ack_single: ack=%b expected 0", cmdAck);
        end
        repeat (19) tick();
        junction = 1'b1;
        tick();
        tick();
        vectors++;
        if (motorCmd !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL left_edge2: motorCmd=%b expected 001", motorCmd);
        end
        tick();
        vectors++;
        if (motorCmd !== 3'b010) begin
            miscompares++;
            $display("[TB] FAIL left_edge3: motorCmd=%b expected 010", motorCmd);
        end
        measureRun(3'b010, len, busyLow);
        vectors++;
        if (len != 8) begin
            miscompares++;
            $display("[TB] FAIL left_turn_len: cycles=%0d expected 8", len);
        end
        vectors++;
        if (motorCmd !== 3'b001 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL left_exit: motorCmd=%b busy=%b expected 001 1", motorCmd, busy);
        end
        junction = 1'b0;
        tick();
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL left_exit_wait_sync: busy=%b expected 1", busy);
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || motorCmd !== 3'b001) begin
            miscompares++;
            $display("[TB] FAIL left_back_idle: busy=%b motorCmd=%b expected 0 001", busy, motorCmd);
        end
    endtask

    task automatic test_back();
        int len, busyLow;
        tdDir = 3'b011;
        tick();
        vectors++;
        if (cmdAck !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL back_ack: ack=%b busy=%b expected 1 1", cmdAck, busy);
        end
        tdDir = 3'b100;
        repeat (5) tick();
        junction = 1'b1;
        repeat (3) tick();
        measureRun(3'b100, len, busyLow);
        vectors++;
        if (len != 16) begin
            miscompares++;
            $display("[TB] FAIL back_spin_len: cycles=%0d expected 16", len);
        end
        vectors++;
        if (busyLow != 0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL back_busy: low_samples=%0d busy_in_exit=%b expected 0 1", busyLow, busy);
        end
        junction = 1'b0;
        repeat (3) tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL back_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_timeout();
        tdDir = 3'b010;
        tick();
        repeat (99) tick();
        vectors++;
        if (timeoutErr !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_early: terr=%b busy=%b expected 0 1", timeoutErr, busy);
        end
        tick();
        vectors++;
        if (timeoutErr !== 1'b1 || motorCmd !== 3'b000 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_error: terr=%b motorCmd=%b busy=%b expected 1 000 0",
                     timeoutErr, motorCmd, busy);
        end
        tick();
        vectors++;
        if (timeoutErr !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL timeout_hold: terr=%b expected 1", timeoutErr);
        end
        tdDir = 3'b100;
        tick();
        vectors++;
        if (timeoutErr !== 1'b0 || motorCmd !== 3'b001 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL timeout_recover: terr=%b motorCmd=%b busy=%b expected 0 001 0",
                     timeoutErr, motorCmd, busy);
        end
    endtask

    task automatic test_hold();
        int len, busyLow, bad;
        // Level already high before a LEFT latch must not start the turn.
        junction = 1'b1;
        repeat (4) tick();
        tdDir = 3'b001;
        tick();
        tdDir = 3'b100;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (motorCmd !== 3'b001) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL hold_left_no_turn: non_fwd_samples=%0d expected 0", bad);
        end
        junction = 1'b0;
        repeat (3) tick();
        junction = 1'b1;
        repeat (3) tick();
        measureRun(3'b010, len, busyLow);
        vectors++;
        if (len != 8) begin
            miscompares++;
            $display("[TB] FAIL hold_left_fresh_edge: cycles=%0d expected 8", len);
        end
        junction = 1'b0;
        repeat (3) tick();
        // STRAIGHT latched with junction high, then held through EXIT.
        junction = 1'b1;
        repeat (4) tick();
        tdDir = 3'b000;
        tick();
        vectors++;
        if (cmdAck !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL hold_straight_ack: ack=%b expected 1", cmdAck);
        end
        repeat (20) tick();
        junction = 1'b0;
        repeat (3) tick();
        junction = 1'b1;
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (cmdAck !== 1'b0 || timeoutErr !== 1'b0 || busy !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL hold_exit_stuck: bad_samples=%0d expected 0", bad);
        end
        junction = 1'b0;
        repeat (5) tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL hold_exit_needs_stop: busy=%b expected 1", busy);
        end
        tdDir = 3'b100;
        tick();
        vectors++;
        if (busy !== 1'b0 || cmdAck !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hold_release: busy=%b ack=%b expected 0 0", busy, cmdAck);
        end
    endtask

    task automatic test_finish();
        int bad;
        tdDir = 3'b111;
        tick();
        vectors++;
        if (finished !== 1'b1 || motorCmd !== 3'b000 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL finish_enter: fin=%b motorCmd=%b busy=%b expected 1 000 0",
                     finished, motorCmd, busy);
        end
        bad = 0;
        for (int i = 0; i < 24; i++) begin
            tdDir = 3'(i % 8);
            junction = i[1];
            tick();
            if (finished !== 1'b1 || motorCmd !== 3'b000 || cmdAck !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("[TB] FAIL finish_sticky: bad_samples=%0d expected 0", bad);
        end
        tdDir = 3'b100;
        junction = 1'b0;
        rst = 1'b0;
        #1;
        vectors++;
        if (finished !== 1'b0 || motorCmd !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL finish_reset_clear: fin=%b motorCmd=%b expected 0 000", finished, motorCmd);
        end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_turn();
        tdDir = 3'b010;
        tick();
        tdDir = 3'b100;
        repeat (2) tick();
        junction = 1'b1;
        repeat (3) tick();
        vectors++;
        if (motorCmd !== 3'b011) begin
            miscompares++;
            $display("[TB] FAIL midturn_enter: motorCmd=%b expected 011", motorCmd);
        end
        repeat (3) tick();
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (motorCmd !== 3'b000 || busy !== 1'b0 || cmdAck !== 1'b0 ||
            finished !== 1'b0 || timeoutErr !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midturn_async_reset: motorCmd=%b busy=%b ack=%b fin=%b terr=%b expected 000 0 0 0 0",
                     motorCmd, busy, cmdAck, finished, timeoutErr);
        end
        junction = 1'b0;
        tick();
        vectors++;
        if (motorCmd !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL midturn_reset_held: motorCmd=%b expected 000", motorCmd);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (motorCmd !== 3'b001 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midturn_release: motorCmd=%b busy=%b expected 001 0", motorCmd, busy);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        tdDir = 3'b100;
        junction = 1'b0;
        test_reset();
        test_left();
        test_back();
        test_timeout();
        test_hold();
        test_finish();
        test_reset_mid_turn();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
